// File: rtl/alien_fire_pkg.sv
// rtl/alien_fire_pkg.sv - shared state encoding and default geometry for the alien bomb scheduler
package alien_fire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        WAIT,
        SCAN,
        REQ
    } fire_state_t;

    localparam int RND_W      = 10;
    localparam int NUM_COLS   = 11;
    localparam int COL_W      = 4;
    localparam int MIN_DELAY  = 16;
    localparam int DELAY_BITS = 6;

    // Counter must hold MIN_DELAY + 2**DELAY_BITS - 1.
    function automatic int delay_cnt_width(input int min_delay, input int delay_bits);
        return $clog2(min_delay + (1 << delay_bits));
    endfunction

endpackage

// File: rtl/frame_delay_cnt.sv
// rtl/frame_delay_cnt.sv - loadable frame down-counter with a done strobe on the 1->0 tick
module frame_delay_cnt
    import alien_fire_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count_en,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Combinational so the owner can leave its wait state on the same edge the count hits 0.
    assign done = count_en && tick && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count_en && tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alien_fire_scheduler.sv
// rtl/alien_fire_scheduler.sv - picks when and from which column the next alien bomb drops
// Optional ALIEN_FIRE_SPEEDUP_EN adds speed_lvl to shorten the frame delay.
module alien_fire_scheduler #(
    parameter int RND_W      = alien_fire_pkg::RND_W,
    parameter int NUM_COLS   = alien_fire_pkg::NUM_COLS,
    parameter int COL_W      = alien_fire_pkg::COL_W,
    parameter int MIN_DELAY  = alien_fire_pkg::MIN_DELAY,
    parameter int DELAY_BITS = alien_fire_pkg::DELAY_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                frame_tick,
    input  logic [RND_W-1:0]    rnd_val,
    input  logic [NUM_COLS-1:0] alive_cols,
    input  logic                drop_ack,
`ifdef ALIEN_FIRE_SPEEDUP_EN
    input  logic [1:0]          speed_lvl,
`endif
    output logic                rnd_rise,
    output logic                drop_req,
    output logic [COL_W-1:0]    drop_col,
    output logic                no_target
);
    import alien_fire_pkg::*;

    localparam int CNT_W = delay_cnt_width(MIN_DELAY, DELAY_BITS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    fire_state_t      state;
    logic [COL_W-1:0] scan_idx;
    logic [COL_W-1:0] scan_cnt;
    logic [CNT_W-1:0] delay_sum;
    logic [CNT_W-1:0] delay_val;
    logic [CNT_W-1:0] delay_cnt;
    logic             delay_done;
    logic [COL_W-1:0] rnd_col;
    logic [COL_W-1:0] start_col;

    assign delay_sum = CNT_W'(MIN_DELAY) + CNT_W'(rnd_val[DELAY_BITS-1:0]);

`ifdef ALIEN_FIRE_SPEEDUP_EN
    logic [CNT_W-1:0] delay_shifted;
    assign delay_shifted = delay_sum >> speed_lvl;
    assign delay_val     = (delay_shifted == '0) ? CNT_W'(1) : delay_shifted;
`else
    assign delay_val = delay_sum;
`endif

    // Top random bits pick the first column; out-of-range values fold back once.
    assign rnd_col   = rnd_val[RND_W-1 -: COL_W];
    assign start_col = ({1'b0, rnd_col} >= (COL_W+1)'(NUM_COLS)) ? rnd_col - COL_W'(NUM_COLS) : rnd_col;

    frame_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     ((state == LOAD) && enable),
        .load_val (delay_val),
        .count_en (state == WAIT),
        .tick     (frame_tick),
        .cnt      (delay_cnt),
        .done     (delay_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rnd_rise  <= 1'b0;
            drop_req  <= 1'b0;
            drop_col  <= '0;
            no_target <= 1'b0;
            scan_idx  <= '0;
            scan_cnt  <= '0;
        end else begin
            rnd_rise  <= 1'b0;
            no_target <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= ARM;
                        rnd_rise <= 1'b1;
                    end
                end
                ARM: begin
                    state <= enable ? LOAD : IDLE;
                end
                LOAD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        scan_idx <= start_col;
                        scan_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (delay_done) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (alive_cols[scan_idx]) begin
                        drop_col <= scan_idx;
                        drop_req <= 1'b1;
                        state    <= REQ;
                    end else if (scan_cnt == LAST_COL) begin
                        no_target <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        scan_idx <= (scan_idx == LAST_COL) ? '0 : scan_idx + 1'b1;
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                REQ: begin
                    // The bomb handshake always completes, regardless of enable.
                    if (drop_ack) begin
                        drop_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb/tb_alien_fire_scheduler.sv - self-checking bench for alien_fire_scheduler
module tb_alien_fire_scheduler;

    localparam int RND_W      = 10;
    localparam int NUM_COLS   = 11;
    localparam int COL_W      = 4;
    localparam int MIN_DELAY  = 16;
    localparam int DELAY_BITS = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                frame_tick;
    logic [RND_W-1:0]    rnd_val;
    logic [NUM_COLS-1:0] alive_cols;
    logic                drop_ack;
    logic                rnd_rise;
    logic                drop_req;
    logic [COL_W-1:0]    drop_col;
    logic                no_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alien_fire_scheduler dut (
`ifdef ALIEN_FIRE_SPEEDUP_EN
        .speed_lvl  (2'b00),
`endif
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .rnd_val    (rnd_val),
        .alive_cols (alive_cols),
        .drop_ack   (drop_ack),
        .rnd_rise   (rnd_rise),
        .drop_req   (drop_req),
        .drop_col   (drop_col),
        .no_target  (no_target)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offset (0..NUM_COLS-1) from start of the first living column, or -1 if none.
    function automatic int first_alive(input int start, input logic [NUM_COLS-1:0] alive);
        for (int k = 0; k < NUM_COLS; k++)
            if (alive[(start + k) % NUM_COLS]) return k;
        return -1;
    endfunction

    task automatic reset_pulse(input string tag);
        #1 reset = 1'b1;
        #1 check(tag, {25'd0, rnd_rise, drop_req, drop_col, no_target}, 32'd0);
        #2 reset = 1'b0;
    endtask

    task automatic wait_rise(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rnd_rise) begin
                got = 1'b1;
                return;
            end
            step();
        end
        check("rise_timeout", 32'd0, 32'd1);
    endtask

    // mode: 0 normal, 1 reset in WAIT, 2 enable low in WAIT, 3 reset in REQ, 4 enable low during REQ hold
    task automatic run_round(input logic [RND_W-1:0] rv, input logic [NUM_COLS-1:0] alive,
                             input int hold, input int mode);
        int delay, start, off, exp_col, bad;
        bit got;
        alive_cols = alive;
        wait_rise(got);
        if (!got) return;
        rnd_val    = rv;
        frame_tick = 1'b1;
        step();
        check("rise_single", rnd_rise, 0);
        step();
        frame_tick = 1'b0;
        delay   = MIN_DELAY + (int'(rv) % (1 << DELAY_BITS));
        start   = (int'(rv) >> (RND_W - COL_W)) % NUM_COLS;
        off     = first_alive(start, alive);
        exp_col = (start + off) % NUM_COLS;
        bad     = 0;
        for (int t = 0; t < delay; t++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                bad += int'(drop_req | no_target | rnd_rise);
            end
            if (mode == 1 && t == delay / 2) begin
                check("wait_quiet_before_reset", bad, 0);
                reset_pulse("reset_in_wait");
                return;
            end
            if (mode == 2 && t == delay / 2) begin
                enable = 1'b0;
                bad    = 0;
                repeat (delay + 10) begin
                    frame_tick = 1'b1;
                    step();
                    frame_tick = 1'b0;
                    step();
                    bad += int'(drop_req | no_target | rnd_rise);
                end
                check("disabled_no_drop", bad, 0);
                enable = 1'b1;
                return;
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            bad += int'(drop_req | no_target | rnd_rise);
        end
        check("wait_quiet", bad, 0);
        bad = 0;
        if (off >= 0) begin
            repeat (off) begin
                step();
                bad += int'(drop_req | no_target);
            end
            step();
            check("scan_no_early_req", bad, 0);
            check("drop_req_set", drop_req, 1);
            check("drop_col", drop_col, exp_col);
            if (mode == 3) begin
                reset_pulse("reset_in_req");
                return;
            end
            if (mode == 4) enable = 1'b0;
            bad = 0;
            repeat (hold) begin
                step();
                bad += int'(drop_req !== 1'b1 || drop_col !== COL_W'(exp_col));
            end
            check("req_hold_stable", bad, 0);
            drop_ack = 1'b1;
            step();
            drop_ack = 1'b0;
            check("req_release", drop_req, 0);
            enable = 1'b1;
        end else begin
            repeat (NUM_COLS - 1) begin
                step();
                bad += int'(drop_req | no_target);
            end
            step();
            check("scan_quiet_no_target", bad, 0);
            check("no_target_pulse", {drop_req, no_target}, 2'b01);
            step();
            check("no_target_once", no_target, 0);
            check("rearm_after_miss", rnd_rise, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        frame_tick = 1'b0;
        drop_ack   = 1'b0;
        rnd_val    = '0;
        alive_cols = '0;
        #2 check("reset_outputs", {25'd0, rnd_rise, drop_req, drop_col, no_target}, 32'd0);
        step();
        step();
        #2 reset = 1'b0;
        step();
        step();
        check("idle_no_rise", rnd_rise, 0);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        check("stray_ack_ignored", drop_req, 0);
        enable = 1'b1;
        step();
        check("rise_after_idle", rnd_rise, 1);

        run_round(10'h005, '1, 3, 0);
        run_round(10'h340, 11'b000_1000_0000, 2, 0);
        run_round(10'h240, 11'b000_0000_0010, 2, 0);
        run_round(10'h0A3, '0, 0, 0);
        run_round(RND_W'($urandom), '1, 50, 4);
        run_round(RND_W'($urandom), NUM_COLS'($urandom), 0, 1);
        run_round(RND_W'($urandom), '1, 0, 3);
        run_round(RND_W'($urandom), '1, 0, 2);
        for (int r = 0; r < 8; r++) begin
            run_round(RND_W'($urandom),
                      ($urandom_range(0, 4) == 0) ? '0 : NUM_COLS'($urandom),
                      $urandom_range(0, 5), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alien_fire_scheduler.md
Name: alien_fire_scheduler

Overview:
Consumes the latched random value from the random-number block and decides when and from which alien column the next enemy bomb drops. It issues the one-cycle "rise" strobe that makes the random block latch a fresh value. It waits a random number of frames, then scans for a living column starting at a random index. It hands the chosen column to the bomb object through a req/ack handshake.

Parameters:
RND_W, 10, width of the random value input (matches random block SIZE_BITS)
NUM_COLS, 11, number of alien columns
COL_W, 4, width of column index (must satisfy 2**COL_W >= NUM_COLS)
MIN_DELAY, 16, minimum frames between sample and drop
DELAY_BITS, 6, low random bits added to MIN_DELAY (delay range 16..79)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  game running; low aborts scheduling (except REQ)
frame_tick  in  1  one-cycle pulse per video frame
rnd_val  in  RND_W  latched value from random block dout
alive_cols  in  NUM_COLS  bit i = column i has at least one living alien
drop_ack  in  1  bomb object accepted drop_col
rnd_rise  out  1  registered strobe to random block "rise" input
drop_req  out  1  registered request, held until drop_ack
drop_col  out  COL_W  column to fire from, stable while drop_req=1
no_target  out  1  one-cycle pulse: scan found no living column

Behaviour:
- Reset: all outputs 0; state IDLE; delay counter 0; scan index 0; scan count 0.
- States: IDLE, ARM, LOAD, WAIT, SCAN, REQ.
- IDLE: enable=1 -> ARM.
- ARM: rnd_rise=1 for exactly this one cycle; -> LOAD. rnd_rise is low in every other state, so the random block sees a clean rising edge each round.
- LOAD: rnd_val is valid (random block latched at ARM's closing edge).
  - delay_cnt <= MIN_DELAY + rnd_val[DELAY_BITS-1:0].
  - start <= rnd_val[RND_W-1 -: COL_W]; if start >= NUM_COLS, use start - NUM_COLS.
  - Scan index <= start; scan count <= 0; -> WAIT.
- WAIT: each frame_tick decrements delay_cnt. A tick that takes delay_cnt from 1 to 0 moves to SCAN next cycle. Ticks outside WAIT are ignored. Total latency is delay_cnt ticks after LOAD.
- SCAN: checks one column per cycle; alive_cols is sampled live.
  - alive_cols[idx]=1 -> drop_col <= idx, drop_req <= 1, -> REQ.
  - Else idx <= (idx == NUM_COLS-1) ? 0 : idx+1; count++.
  - After NUM_COLS misses (count == NUM_COLS-1 with a miss): no_target pulses 1 cycle, -> IDLE.
- REQ: drop_req and drop_col are held. On the cycle drop_ack=1: drop_req <= 0 -> IDLE. drop_ack while drop_req=0 is ignored. enable is ignored in REQ; the handshake always completes.
- enable=0 in ARM/LOAD/WAIT/SCAN: -> IDLE next cycle, rnd_rise <= 0, no request issued.
- Width rule: delay sum computed at DELAY_BITS+1 bits minimum; MIN_DELAY + 2**DELAY_BITS - 1 must fit the counter width.
- Reset mid-operation (any state, including REQ with drop_req=1): immediate return to the reset values.

Optional Feature:
ALIEN_FIRE_SPEEDUP_EN:
- Defined: adds input speed_lvl [1:0]. In LOAD, delay_cnt <= (MIN_DELAY + rnd bits) >> speed_lvl, clamped to at least 1.
- Undefined: port absent; delay is unshifted.

Decomposition:
- Package alien_fire_pkg: state enum (IDLE, ARM, LOAD, WAIT, SCAN, REQ), NUM_COLS, COL_W, MIN_DELAY, DELAY_BITS constants.
- One sub-module, frame_delay_cnt: loadable down-counter decremented by frame_tick, with a done pulse on the 1->0 transition.

Test Plan:
- Reset, enable=1: rnd_rise high exactly one cycle, 1 cycle after leaving IDLE. rnd_val=10'h005, alive_cols=all ones: 21 frame_ticks -> drop_req=1, drop_col=0. Start = rnd[9:6]=0.
- rnd_val=10'b1101_000000: start=13-11=2, delay=16. alive_cols=11'b000_1000_0000: scan 2..7 -> drop_col=7 on the 6th SCAN cycle.
- Wrap: start=9, only column 1 alive -> scan 9,10,0,1 -> drop_col=1.
- alive_cols=0 at SCAN: no_target pulses once after 11 SCAN cycles; drop_req never asserts; FSM re-arms (rnd_rise) if enable=1.
- drop_ack held 0 for 50 cycles with enable dropped: drop_req and drop_col stay stable. drop_ack=1 -> drop_req=0 next cycle.
- Assert reset during WAIT and during REQ: all outputs 0 immediately; enable=0 during WAIT -> IDLE, no drop_req for any further frame_tick.
